// File: rtl/list_sum_datapath.sv
// Datapath for the linked-list summation engine: node memory, running sum,
// next-node pointer, saturating node counter and sticky overflow flag.
module list_sum_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int SUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_sum,
    input  logic              ld_next,
    input  logic              sum_sel,
    input  logic              next_sel,
    input  logic              a_sel,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              next_zero,
    output logic [SUM_W-1:0]  sum,
    output logic [ADDR_W:0]   node_cnt,
    output logic              ovf,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W-1:0] ptr_addr;
    logic [ADDR_W-1:0] a_addr;
    logic [SUM_W:0]    sum_add;

    // Pointer word sits one above the value word and wraps within the memory.
    assign ptr_addr  = next_ptr + ADDR_W'(1);
    assign a_addr    = a_sel ? next_ptr : ptr_addr;
    assign rdata     = mem[a_addr];
    assign next_zero = (mem[ptr_addr] == '0);
    assign sum_add   = {1'b0, sum} + (SUM_W+1)'(rdata);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            next_ptr <= '0;
            node_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (ld_sum) begin
                if (sum_sel) begin
                    sum <= sum_add[SUM_W-1:0];
                    ovf <= ovf | sum_add[SUM_W];
                    if (node_cnt != '1)
                        node_cnt <= node_cnt + (ADDR_W+1)'(1);
                end else begin
                    sum      <= '0;
                    node_cnt <= '0;
                    ovf      <= 1'b0;
                end
            end
            if (ld_next)
                next_ptr <= next_sel ? rdata[ADDR_W-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_list_sum_datapath.sv
// Scoreboard bench for list_sum_datapath: directed list walks plus random
// control traffic against an array-based reference model.
module tb_list_sum_datapath;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int SW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << (AW + 1)) - 1;

    typedef struct {
        logic [SW-1:0] sum;
        logic [AW:0]   cnt;
        logic          ovf;
        logic [DW-1:0] rdata;
        logic          nz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_sum, ld_next, sum_sel, next_sel, a_sel, mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          next_zero;
    logic [SW-1:0] sum;
    logic [AW:0]   node_cnt;
    logic          ovf;
    logic [DW-1:0] rdata;

    int   mem_m [DEPTH];
    int   sum_m, next_m, cnt_m;
    bit   ovf_m;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    list_sum_datapath #(.DATA_W(DW), .ADDR_W(AW), .SUM_W(SW)) dut (
        .clk(clk), .rst(rst), .ld_sum(ld_sum), .ld_next(ld_next),
        .sum_sel(sum_sel), .next_sel(next_sel), .a_sel(a_sel),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .next_zero(next_zero), .sum(sum), .node_cnt(node_cnt), .ovf(ovf),
        .rdata(rdata)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of controls, queue what the outputs must show before the
    // edge, then advance the reference model across the edge.
    task automatic step(bit ls, bit ln, bit ss, bit ns, bit as,
                        bit we = 0, int wa = 0, int wd = 0,
                        bit r = 0, bit check = 1);
        exp_t e;
        int   rd, t;
        ld_sum = ls; ld_next = ln; sum_sel = ss; next_sel = ns; a_sel = as;
        mem_we = we; mem_waddr = AW'(wa); mem_wdata = DW'(wd); rst = r;
        if (r) begin
            sum_m = 0; next_m = 0; cnt_m = 0; ovf_m = 0;
        end
        rd = mem_m[as ? next_m : (next_m + 1) % DEPTH];
        if (check) begin
            e.sum   = SW'(sum_m);
            e.cnt   = (AW+1)'(cnt_m);
            e.ovf   = ovf_m;
            e.rdata = DW'(rd);
            e.nz    = (mem_m[(next_m + 1) % DEPTH] == 0);
            q.push_back(e);
        end
        @(posedge clk);
        if (!r) begin
            if (ls && ss) begin
                t = sum_m + rd;
                if (t >= (1 << SW)) ovf_m = 1;
                sum_m = t % (1 << SW);
                cnt_m = (cnt_m < CMAX) ? cnt_m + 1 : CMAX;
            end else if (ls) begin
                sum_m = 0; cnt_m = 0; ovf_m = 0;
            end
            if (ln) next_m = ns ? rd % DEPTH : 0;
        end
        if (we) mem_m[wa] = wd;
        #1;
    endtask

    task automatic clr();  step(1, 0, 0, 1, 1); endtask
    task automatic acc();  step(1, 0, 1, 1, 1); endtask
    task automatic getn(); step(0, 1, 1, 1, 0); endtask
    task automatic nop();  step(0, 0, 0, 0, 1); endtask
    task automatic wr(int a, int d); step(0, 0, 0, 0, 1, 1, a, d); endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sum", sum, e.sum);
            chk("node_cnt", node_cnt, e.cnt);
            chk("ovf", ovf, e.ovf);
            chk("rdata", rdata, e.rdata);
            chk("next_zero", next_zero, e.nz);
        end
    end

    initial begin
        int v;
        rst = 1; ld_sum = 0; ld_next = 0; sum_sel = 0; next_sel = 0;
        a_sel = 0; mem_we = 0; mem_waddr = '0; mem_wdata = '0;
        sum_m = 0; next_m = 0; cnt_m = 0; ovf_m = 0;
        @(posedge clk); #1;

        // Preload under reset: three-node list {5->4, 7->8, 9->0}.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0: v = 5;  1: v = 4;  4: v = 7;  5: v = 8;
                8: v = 9;  9: v = 0;
                default: v = $urandom_range(1, 255);
            endcase
            step(0, 0, 0, 0, 0, 1, i, v, 1, 0);
        end
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        chk("reset_sum", sum, 0);
        chk("reset_rdata", rdata, 5);

        // Three-node sum
        clr(); acc();
        chk("nz_node1", next_zero, 0);
        getn(); acc();
        chk("nz_node2", next_zero, 0);
        getn(); acc();
        chk("nz_node3", next_zero, 1);
        getn();
        chk("three_sum", sum, 21);
        chk("three_cnt", node_cnt, 3);
        chk("three_ovf", ovf, 0);

        // Async reset between edges after sum=12, next=4
        clr(); acc(); getn(); acc();
        chk("pre_rst_sum", sum, 12);
        chk("pre_rst_nz", next_zero, 0);
        rst = 1; #1;
        chk("async_sum", sum, 0);
        chk("async_cnt", node_cnt, 0);
        a_sel = 1; #1;
        chk("async_next", rdata, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        chk("mem_keep1", rdata, 4);

        // Single node
        wr(0, 13); wr(1, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        chk("single_nz", next_zero, 1);
        clr(); acc();
        chk("single_sum", sum, 13);

        // Pointer wrap: next=15 reads its pointer word from address 0
        wr(1, 15); clr(); getn();
        a_sel = 0; #1;
        chk("wrap_rdata", rdata, 13);
        chk("wrap_nz", next_zero, 0);
        wr(0, 0);
        chk("wrap_nz_after", next_zero, 1);

        // Write/read collision on the pointer word of node 0
        step(0, 1, 0, 0, 0);
        wr(0, 13);
        chk("coll_before", next_zero, 0);
        wr(1, 0);
        chk("coll_after", next_zero, 1);

        // Overflow and counter saturation with value 255 at node 0
        wr(0, 255); clr();
        repeat (17) acc();
        chk("ovf_set", ovf, 1);
        chk("ovf_sum", sum, 17 * 255 - 4096);
        chk("ovf_cnt", node_cnt, 17);
        repeat (3) nop();
        chk("ovf_hold", ovf, 1);
        repeat (23) acc();
        chk("sat_cnt", node_cnt, CMAX);
        chk("sat_sum", sum, (40 * 255) % 4096);
        clr();
        chk("ovf_clear", ovf, 0);
        chk("cnt_clear", node_cnt, 0);

        // Random control traffic
        for (int n = 0; n < 400; n++) begin
            bit we, r;
            we = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), we, $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 255), r, 1);
        end
        nop();

        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/list_sum_datapath.md
# list_sum_datapath

Datapath for the linked-list summation engine. It sits directly downstream of the list-sum FSM controller: it consumes `ld_sum`, `ld_next`, `sum_sel`, `next_sel` and `a_sel`, and returns `next_zero`. It holds the node memory, the running sum, the next-node pointer, a node counter and a sticky overflow flag. The memory is preloaded through a dedicated write port before a run.

## Interface
- `DATA_W`, 8: width of each memory word, holding either a value or a pointer. Must be ≥ `ADDR_W`.
- `ADDR_W`, 4: memory address width, giving a depth of 2^`ADDR_W` words.
- `SUM_W`, 12: width of the sum register. Must be ≥ `DATA_W`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `ld_sum`  in  1  load enable for the sum register.
- `ld_next`  in  1  load enable for the next-pointer register.
- `sum_sel`  in  1  sum source: 1 = sum + rdata (accumulate), 0 = 0 (clear).
- `next_sel`  in  1  pointer source: 1 = rdata, 0 = 0 (list head).
- `a_sel`  in  1  read address: 1 = next (value word), 0 = next+1 (pointer word).
- `mem_we`  in  1  preload write enable.
- `mem_waddr`  in  ADDR_W  preload write address.
- `mem_wdata`  in  DATA_W  preload write data.
- `next_zero`  out  1  the current node's pointer word is 0.
- `sum`  out  SUM_W  running sum register.
- `node_cnt`  out  ADDR_W+1  number of nodes accumulated since the last clear.
- `ovf`  out  1  sticky flag for sum carry-out.
- `rdata`  out  DATA_W  combinational memory read data at the `a_sel` address (debug/observe).

## Operation
- Node layout: the value is at address p and the pointer is at address p+1. Pointer value 0 is null. The list head is at address 0.
- Pointer words use their low `ADDR_W` bits as the address. The sum p+1 wraps modulo 2^`ADDR_W`.
- Memory: 2^`ADDR_W` × `DATA_W`, not reset.
  - Synchronous write: when `mem_we`=1, mem[`mem_waddr`] <= `mem_wdata` at the edge.
  - Read is asynchronous and combinational.
- Read port A: `rdata` = mem[`a_sel` ? next : next+1].
- Read port B (internal): `next_zero` = (mem[next+1] == 0). This is combinational and independent of `a_sel`, so the controller can sample it on the same edge that loads the pointer.
- Sum register:
  - `ld_sum`=1, `sum_sel`=1: sum <= (sum + zero-extended `rdata`) mod 2^`SUM_W`.
  - `ld_sum`=1, `sum_sel`=0: sum <= 0.
- Next register: when `ld_next`=1, next <= `next_sel` ? `rdata`[ADDR_W-1:0] : 0.
- node_cnt:
  - Increments on each accumulate (`ld_sum`=1, `sum_sel`=1).
  - Cleared to 0 on a clear (`ld_sum`=1, `sum_sel`=0).
  - Saturates at 2^(`ADDR_W`+1)−1.
- ovf:
  - Set on any accumulate whose addition carries out of `SUM_W` bits.
  - Cleared only by a clear or by `rst`. Holds otherwise.
- Simultaneous `ld_sum` and `ld_next`: both registers update from the same pre-edge `rdata`.
- `mem_we` on an address being read: reads during that cycle return the old data. The new data is visible after the edge.
- No control asserted: all registers hold.

## Timing
- Reset (async, immediate on `rst` rising, independent of `clk`): sum=0, next=0, node_cnt=0, ovf=0. `next_zero` and `rdata` then reflect memory at addresses 1 and 0 respectively.
- Reset mid-run discards all register state. Memory contents are preserved.
- Register latency is 1 cycle: a control sampled at edge N updates its register at edge N.
- `rdata` and `next_zero` settle combinationally within the same cycle after next or memory changes.
- Controller handshake:
  - The COMPUTE_SUM controls (`ld_sum`=1, `sum_sel`=1, `next_sel`=1, `a_sel`=1) add the value word.
  - The GET_NEXT controls (`ld_next`=1, `sum_sel`=1, `next_sel`=1, `a_sel`=0) load the pointer.
  - `next_zero` is valid during GET_NEXT, before the loading edge.
- No state other than memory changes while `rst` is high.

## Test plan
- **Three-node sum.** Preload mem[0..1]={5,4}, mem[4..5]={7,8}, mem[8..9]={9,0}. Clear, then alternate accumulate/get-next.
  - Required: sum=21, node_cnt=3, ovf=0.
  - `next_zero`=0 during the first two pointer phases and =1 during the third.
- **Single node.** mem[0]=13, mem[1]=0, one accumulate.
  - Required: sum=13, `next_zero`=1 immediately after reset.
- **Overflow (`SUM_W`=8).** Values 200 then 100.
  - Required: sum=44, ovf=1.
  - ovf holds through further no-op cycles and clears to 0 on a clear.
- **Pointer wrap.** Pointer 15 with `ADDR_W`=4.
  - Required: the pointer word is read from address 0.
  - `next_zero` reflects mem[0].
- **Async reset mid-run.** Assert `rst` between clock edges after sum=12, next=4.
  - Required: sum=0, next=0, node_cnt=0 before the next edge.
  - Memory is unchanged when read back.
- **Write/read collision.** `mem_we` to address 1 with data 0 while next=0.
  - Required: `next_zero` keeps its old value until the edge, then reads 1.
